// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner: prescaled digit slots with ghost guard, hex/decimal
// decode, leading-zero blanking, per-digit blink and frame-synchronous tear-free loading.
module seg_scan #(
   parameter int unsigned NUM_DIGITS   = 6,
   parameter int unsigned PRESCALE     = 1000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    load,
   input  logic                    hex_mode,
   input  logic                    lz_blank,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [6:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_done,
   output logic                    load_ack
);

   localparam int unsigned PW = $clog2(PRESCALE);
   localparam int unsigned IW = $clog2(NUM_DIGITS);
   localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   logic [PW-1:0]           presc_q, presc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [FW-1:0]           fcnt_q, fcnt_d;
   logic                    blink_q, blink_d;
   logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
   logic                    pflag_q, pflag_d;
   logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
   logic [6:0]              seg_d;
   logic [NUM_DIGITS-1:0]   an_d;
   logic                    frame_done_d;
   logic                    load_ack_d;

   logic [3:0]              nib [NUM_DIGITS];
   logic [IW-1:0]           hi;
   logic [3:0]              cur;

   function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic hex);
      logic [6:0] s;
      s = SEG_BLANK;
      case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = hex ? 7'b0001000 : SEG_BLANK;
         4'hB: s = hex ? 7'b1100000 : SEG_BLANK;
         4'hC: s = hex ? 7'b0110001 : SEG_BLANK;
         4'hD: s = hex ? 7'b1000010 : SEG_BLANK;
         4'hE: s = hex ? 7'b0110000 : SEG_BLANK;
         default: s = hex ? 7'b0111000 : SEG_BLANK;
      endcase
      return s;
   endfunction

   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
         nib[k] = disp_q[4*k +: 4];
      end
   end

   // Index of the most significant non-zero nibble; zero when the whole value is zero.
   always_comb begin
      hi = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (nib[k] != 4'h0) begin
            hi = IW'(k);
         end
      end
   end

   assign cur = nib[idx_q];

   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PMAX) begin
         presc_d = '0;
         idx_d   = (idx_q == IMAX) ? '0 : idx_q + IW'(1);
      end
   end

   always_comb begin
      fcnt_d  = fcnt_q;
      blink_d = blink_q;
      if (frame_done) begin
         if (fcnt_q == FMAX) begin
            fcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
   end

   // Display register only changes at the frame boundary, so a frame never mixes two values.
   always_comb begin
      pend_d     = pend_q;
      pflag_d    = pflag_q;
      disp_d     = disp_q;
      load_ack_d = 1'b0;
      if (frame_done) begin
         if (load) begin
            disp_d     = digits_in;
            pflag_d    = 1'b0;
            load_ack_d = 1'b1;
         end else if (pflag_q) begin
            disp_d     = pend_q;
            pflag_d    = 1'b0;
            load_ack_d = 1'b1;
         end
      end else if (load) begin
         pend_d  = digits_in;
         pflag_d = 1'b1;
      end
   end

   // Outputs register the current slot phase; phase 0 is the guard cycle with all anodes off.
   always_comb begin
      seg_d        = SEG_BLANK;
      an_d         = '1;
      frame_done_d = (presc_q == PMAX) && (idx_q == IMAX);
      if (presc_q != '0) begin
         an_d[idx_q] = 1'b0;
         if (blink_q && blink_mask[idx_q]) begin
            seg_d = SEG_BLANK;
         end else if (lz_blank && (idx_q > hi)) begin
            seg_d = SEG_BLANK;
         end else begin
            seg_d = seg_decode(cur, hex_mode);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q    <= '0;
         idx_q      <= '0;
         fcnt_q     <= '0;
         blink_q    <= 1'b0;
         pend_q     <= '0;
         pflag_q    <= 1'b0;
         disp_q     <= '1;
         seg_o      <= SEG_BLANK;
         an_o       <= '1;
         frame_done <= 1'b0;
         load_ack   <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         fcnt_q     <= fcnt_d;
         blink_q    <= blink_d;
         pend_q     <= pend_d;
         pflag_q    <= pflag_d;
         disp_q     <= disp_d;
         seg_o      <= seg_d;
         an_o       <= an_d;
         frame_done <= frame_done_d;
         load_ack   <= load_ack_d;
      end
   end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: per-cycle expectations for whole frames are queued at load
// time and compared on the falling edge as the scan produces them.
module tb_seg_scan;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] digits_in = 16'h0000;
   logic        load = 1'b0;
   logic        hex_mode = 1'b0;
   logic        lz_blank = 1'b0;
   logic [3:0]  blink_mask = 4'h0;
   logic [6:0]  seg_o;
   logic [3:0]  an_o;
   logic        frame_done;
   logic        load_ack;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] an;
      logic       fd;
      logic       ack;
      logic       chk_seg;
      string      tag;
   } exp_t;

   exp_t sb[$];

   seg_scan #(
      .NUM_DIGITS  (4),
      .PRESCALE    (4),
      .BLINK_FRAMES(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .digits_in (digits_in),
      .load      (load),
      .hex_mode  (hex_mode),
      .lz_blank  (lz_blank),
      .blink_mask(blink_mask),
      .seg_o     (seg_o),
      .an_o      (an_o),
      .frame_done(frame_done),
      .load_ack  (load_ack)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_seg(input logic [3:0] v, input logic hexm);
      case (v)
         4'h0: return 7'b0000001;
         4'h1: return 7'b1001111;
         4'h2: return 7'b0010010;
         4'h3: return 7'b0000110;
         4'h4: return 7'b1001100;
         4'h5: return 7'b0100100;
         4'h6: return 7'b0100000;
         4'h7: return 7'b0001111;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0000100;
         4'hA: return hexm ? 7'b0001000 : 7'h7F;
         4'hB: return hexm ? 7'b1100000 : 7'h7F;
         4'hC: return hexm ? 7'b0110001 : 7'h7F;
         4'hD: return hexm ? 7'b1000010 : 7'h7F;
         4'hE: return hexm ? 7'b0110000 : 7'h7F;
         default: return hexm ? 7'b0111000 : 7'h7F;
      endcase
   endfunction

   // Queue the 16 cycles of one frame: digits 0..3, each a guard cycle then 3 active cycles.
   task automatic push_frame(input logic [15:0] val, input logic hexm, input logic lz,
                             input logic blink_off, input logic ack, input string tag);
      exp_t       e;
      int         hi;
      logic [3:0] nb;
      hi = 0;
      for (int k = 0; k < 4; k++) if (val[4*k +: 4] != 4'h0) hi = k;
      for (int k = 0; k < 4; k++) begin
         for (int p = 0; p < 4; p++) begin
            nb        = val[4*k +: 4];
            e.tag     = tag;
            e.chk_seg = (p != 0);
            e.an      = (p == 0) ? 4'hF : ~(4'b0001 << k);
            e.fd      = (k == 3) && (p == 3);
            e.ack     = ack && (k == 0) && (p == 0);
            if (blink_off && blink_mask[k]) e.seg = 7'h7F;
            else if (lz && k > hi)          e.seg = 7'h7F;
            else                            e.seg = ref_seg(nb, hexm);
            sb.push_back(e);
         end
      end
   endtask

   task automatic run_frames;
      exp_t e;
      int   n;
      n = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         checks++;
         if (an_o !== e.an) begin
            errors++;
            $display("FAIL %s an_o cyc%0d got %b want %b", e.tag, n, an_o, e.an);
         end
         if (e.chk_seg) begin
            checks++;
            if (seg_o !== e.seg) begin
               errors++;
               $display("FAIL %s seg_o cyc%0d got %b want %b", e.tag, n, seg_o, e.seg);
            end
         end
         checks++;
         if (frame_done !== e.fd) begin
            errors++;
            $display("FAIL %s frame_done cyc%0d got %b want %b", e.tag, n, frame_done, e.fd);
         end
         checks++;
         if (load_ack !== e.ack) begin
            errors++;
            $display("FAIL %s load_ack cyc%0d got %b want %b", e.tag, n, load_ack, e.ack);
         end
         n++;
      end
   endtask

   task automatic wait_fd(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (frame_done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s frame_done timeout got none want pulse within 40 cycles", tag);
      end
   endtask

   task automatic do_load(input logic [15:0] val);
      @(negedge clk);
      digits_in = val;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks += 4;
      if (seg_o !== 7'h7F) begin errors++; $display("FAIL rst seg_o got %h want 7f", seg_o); end
      if (an_o !== 4'hF) begin errors++; $display("FAIL rst an_o got %h want f", an_o); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL rst frame_done got %b want 0", frame_done); end
      if (load_ack !== 1'b0) begin errors++; $display("FAIL rst load_ack got %b want 0", load_ack); end
      rst_n = 1'b1;
      push_frame(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, "rst_frame0");
      run_frames();
   endtask

   task automatic test_decimal;
      hex_mode = 1'b0;
      lz_blank = 1'b0;
      do_load(16'h1234);
      wait_fd("dec");
      push_frame(16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, "dec_1234");
      run_frames();
   endtask

   task automatic test_reset_midframe;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (seg_o !== 7'b1001100) begin
         errors++;
         $display("FAIL mid_pre seg_o got %b want 1001100", seg_o);
      end
      digits_in = 16'h5678;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks += 4;
      if (seg_o !== 7'h7F) begin errors++; $display("FAIL mid_rst seg_o got %h want 7f", seg_o); end
      if (an_o !== 4'hF) begin errors++; $display("FAIL mid_rst an_o got %h want f", an_o); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst frame_done got %b want 0", frame_done); end
      if (load_ack !== 1'b0) begin errors++; $display("FAIL mid_rst load_ack got %b want 0", load_ack); end
      @(negedge clk);
      rst_n = 1'b1;
      // Pending 5678 must be gone: two blank frames with no acknowledge.
      push_frame(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, "mid_frame0");
      push_frame(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, "mid_frame1");
      run_frames();
   endtask

   task automatic test_lz;
      lz_blank = 1'b1;
      do_load(16'h0050);
      wait_fd("lz");
      push_frame(16'h0050, 1'b0, 1'b1, 1'b0, 1'b1, "lz_on");
      run_frames();
      lz_blank = 1'b0;
      push_frame(16'h0050, 1'b0, 1'b0, 1'b0, 1'b0, "lz_off");
      run_frames();
   endtask

   task automatic test_hex;
      hex_mode = 1'b1;
      do_load(16'h00AF);
      wait_fd("hex");
      push_frame(16'h00AF, 1'b1, 1'b0, 1'b0, 1'b1, "hex_on");
      run_frames();
      hex_mode = 1'b0;
      push_frame(16'h00AF, 1'b0, 1'b0, 1'b0, 1'b0, "hex_off");
      run_frames();
   endtask

   task automatic test_back_to_back;
      @(negedge clk);
      digits_in = 16'h1111;
      load = 1'b1;
      @(negedge clk);
      digits_in = 16'h2222;
      @(negedge clk);
      load = 1'b0;
      wait_fd("b2b");
      push_frame(16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_2222");
      run_frames();
      // Now sitting in the frame_done cycle: load here lands at this boundary.
      digits_in = 16'h4321;
      load = 1'b1;
      push_frame(16'h4321, 1'b0, 1'b0, 1'b0, 1'b1, "coinc_4321");
      @(posedge clk);
      #1 load = 1'b0;
      run_frames();
   endtask

   task automatic test_blink;
      @(negedge clk);
      rst_n = 1'b0;
      blink_mask = 4'b0001;
      @(negedge clk);
      rst_n = 1'b1;
      push_frame(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, "blink_f0");
      run_frames();
      digits_in = 16'h8888;
      load = 1'b1;
      for (int f = 1; f <= 4; f++) begin
         push_frame(16'h8888, 1'b0, 1'b0, (f == 2) || (f == 3), f == 1,
                    $sformatf("blink_f%0d", f));
      end
      @(posedge clk);
      #1 load = 1'b0;
      run_frames();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_decimal();
      test_reset_midframe();
      test_lz();
      test_hex();
      test_back_to_back();
      test_blink();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
